// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. The fetch side looks up a PC and receives a registered
//   prediction one cycle later; the execute side trains the table with
//   resolved branches. Lookups always observe the table contents from before
//   any same-cycle update or flush (read-before-write).
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   lookup_en    fetch-side lookup request
//   lookup_pc    fetch PC to look up
//   pred_valid   registered: a lookup was issued in the previous cycle
//   pred_taken   registered: lookup hit and counter predicts taken
//   pred_target  registered: predicted target, 0 when not taken
//   upd_en       resolved branch update request
//   upd_pc       PC of the resolved branch
//   upd_taken    resolved outcome
//   upd_target   resolved target
//   flush        synchronous invalidate of every entry
//   hit_count    saturating count of lookups that hit
// ---------------------------------------------------------------------------
module branch_target_buffer #(
    parameter int ENTRIES = 8,
    parameter int IDXW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_en,
    input  logic [31:0] lookup_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush,
    output logic [15:0] hit_count
);

    localparam int TAGW = 32 - IDXW - 2;

    // Counter arithmetic: 0/1 predict not-taken, 2/3 predict taken.
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Table state
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [TAGW-1:0]    tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    // Output / statistics state
    logic        pred_valid_q, pred_valid_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;
    logic [15:0] hit_count_q, hit_count_d;

    // Lookup decode against the current (pre-update) table
    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic            lk_taken;

    // Update decode
    logic [IDXW-1:0] up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;

    always_comb begin
        lk_idx   = lookup_pc[IDXW+1:2];
        lk_tag   = lookup_pc[31:IDXW+2];
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && ctr_q[lk_idx][1];

        up_idx   = upd_pc[IDXW+1:2];
        up_tag   = upd_pc[31:IDXW+2];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    // Prediction outputs and hit statistics
    always_comb begin
        pred_valid_d  = lookup_en;
        pred_taken_d  = lookup_en && lk_taken;
        pred_target_d = (lookup_en && lk_taken) ? target_q[lk_idx] : 32'h0;

        hit_count_d = hit_count_q;
        if (lookup_en && lk_hit && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
    end

    // Table next state. Flush only drops valid bits and wins over an update;
    // counters and targets are kept so only the valid bit gates reuse.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;

        if (flush) begin
            valid_d = '0;
        end else if (upd_en) begin
            if (up_hit) begin
                if (upd_taken) begin
                    ctr_d[up_idx]    = ctr_inc(ctr_q[up_idx]);
                    target_d[up_idx] = upd_target;
                end else begin
                    ctr_d[up_idx]    = ctr_dec(ctr_q[up_idx]);
                end
            end else if (upd_taken) begin
                // Allocate or replace the aliasing entry as weakly taken.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                ctr_d[up_idx]    = 2'b10;
            end
            // Not-taken miss leaves the table untouched.
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            tag_q         <= '{default: '0};
            target_q      <= '{default: '0};
            ctr_q         <= '{default: 2'b01};
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'h0;
            hit_count_q   <= 16'h0;
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            hit_count_q   <= hit_count_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign hit_count   = hit_count_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer
//   Directed bench for branch_target_buffer (ENTRIES=8): cold miss, allocate
//   and hit, counter hysteresis, aliasing replacement, same-cycle
//   read-before-write, pc[1:0] masking, not-taken miss, flush priority and
//   asynchronous reset mid-operation. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_branch_target_buffer;

    logic        clk;
    logic        rst_n;
    logic        lookup_en;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;
    logic [15:0] hit_count;

    int checks   = 0;
    int failures = 0;

    branch_target_buffer #(.ENTRIES(8), .IDXW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_en   (lookup_en),
        .lookup_pc   (lookup_pc),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush       (flush),
        .hit_count   (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lookup_en  = 1'b0;
        lookup_pc  = 32'h0;
        upd_en     = 1'b0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        flush      = 1'b0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_en     = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        tick();
        clear_inputs();
    endtask

    // Single lookup, then check the registered prediction.
    task automatic do_lookup(input string tag, input logic [31:0] pc,
                             input logic exp_taken, input logic [31:0] exp_tgt,
                             input logic [15:0] exp_hits);
        lookup_en = 1'b1;
        lookup_pc = pc;
        tick();
        clear_inputs();
        chk({tag, "_valid"},  {31'h0, pred_valid}, 32'h1);
        chk({tag, "_taken"},  {31'h0, pred_taken}, {31'h0, exp_taken});
        chk({tag, "_target"}, pred_target, exp_tgt);
        chk({tag, "_hits"},   {16'h0, hit_count}, {16'h0, exp_hits});
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid",  {31'h0, pred_valid}, 32'h0);
        chk("rst_taken",  {31'h0, pred_taken}, 32'h0);
        chk("rst_target", pred_target, 32'h0);
        chk("rst_hits",   {16'h0, hit_count}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Cold miss
        do_lookup("cold", 32'h0000_1000, 1'b0, 32'h0, 16'd0);

        // Allocate then hit (counter 2)
        do_upd(32'h0000_1000, 1'b1, 32'h0000_1040);
        do_lookup("alloc", 32'h0000_1000, 1'b1, 32'h0000_1040, 16'd1);

        // Hysteresis: 2 -> 1 -> 0, then 1, then 2
        do_upd(32'h0000_1000, 1'b0, 32'hDEAD_0000);
        do_upd(32'h0000_1000, 1'b0, 32'hDEAD_0000);
        do_lookup("ctr0", 32'h0000_1000, 1'b0, 32'h0, 16'd2);
        do_upd(32'h0000_1000, 1'b1, 32'h0000_1040);
        do_lookup("ctr1", 32'h0000_1000, 1'b0, 32'h0, 16'd3);
        do_upd(32'h0000_1000, 1'b1, 32'h0000_1044);
        do_lookup("ctr2", 32'h0000_1000, 1'b1, 32'h0000_1044, 16'd4);

        // Alias on index 0 replaces the entry
        do_upd(32'h0000_1020, 1'b1, 32'h0000_2000);
        do_lookup("alias_old", 32'h0000_1000, 1'b0, 32'h0, 16'd4);
        do_lookup("alias_new", 32'h0000_1020, 1'b1, 32'h0000_2000, 16'd5);

        // Same-cycle lookup and taken update to an empty index
        upd_en     = 1'b1;
        upd_pc     = 32'h0000_1008;
        upd_taken  = 1'b1;
        upd_target = 32'h0000_3000;
        do_lookup("rbw_same", 32'h0000_1008, 1'b0, 32'h0, 16'd5);
        do_lookup("rbw_next", 32'h0000_1008, 1'b1, 32'h0000_3000, 16'd6);

        // Low PC bits ignored
        do_lookup("pclow", 32'h0000_100B, 1'b1, 32'h0000_3000, 16'd7);

        // Not-taken miss allocates nothing
        do_upd(32'h0000_1010, 1'b0, 32'h0000_4000);
        do_lookup("nt_miss", 32'h0000_1010, 1'b0, 32'h0, 16'd7);

        // Idle cycle: no lookup -> no prediction
        tick();
        chk("idle_valid", {31'h0, pred_valid}, 32'h0);

        // Flush with same-cycle update and lookup (lookup sees pre-flush)
        flush      = 1'b1;
        upd_en     = 1'b1;
        upd_pc     = 32'h0000_1010;
        upd_taken  = 1'b1;
        upd_target = 32'h0000_5000;
        do_lookup("flush_same", 32'h0000_1020, 1'b1, 32'h0000_2000, 16'd8);
        do_lookup("flush_a", 32'h0000_1020, 1'b0, 32'h0, 16'd8);
        do_lookup("flush_upd", 32'h0000_1010, 1'b0, 32'h0, 16'd8);
        do_lookup("flush_b", 32'h0000_1008, 1'b0, 32'h0, 16'd8);

        // Reallocate, then assert reset while a prediction is being presented
        do_upd(32'h0000_1008, 1'b1, 32'h0000_3000);
        lookup_en = 1'b1;
        lookup_pc = 32'h0000_1008;
        tick();
        chk("pre_rst_taken", {31'h0, pred_taken}, 32'h1);
        chk("pre_rst_hits",  {16'h0, hit_count}, 32'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  {31'h0, pred_valid}, 32'h0);
        chk("mid_rst_taken",  {31'h0, pred_taken}, 32'h0);
        chk("mid_rst_target", pred_target, 32'h0);
        chk("mid_rst_hits",   {16'h0, hit_count}, 32'h0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        do_lookup("post_rst", 32'h0000_1008, 1'b0, 32'h0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
